// File: rtl/alu_issue.sv
// alu_issue: issues decoded operands from an 8x32 register file to an external combinational ALU and writes the result back.
// Optional immediate operand path is compiled in when ALU_ISSUE_IMM_EN is defined.
module alu_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [2:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_y,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic [2:0]  res_rd,
    input  logic [2:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;

    logic [31:0] regs_r [8];
    logic [2:0]  rd_r;

    logic        ready_r;
    logic        res_valid_r;
    logic [2:0]  alu_op_r;
    logic [31:0] alu_a_r;
    logic [31:0] alu_b_r;
    logic [31:0] res_data_r;
    logic [2:0]  res_rd_r;

    logic        accept_s;
    logic        wr_en_s;
    logic        ready_nxt_s;
    logic        valid_nxt_s;
    logic [2:0]  op_s;
    logic [2:0]  rd_s;
    logic [2:0]  rs1_s;
    logic [2:0]  rs2_s;
    logic [31:0] rs1_data_s;
    logic [31:0] rs2_data_s;
    logic [31:0] opb_s;
    logic        unused_instr_s;

    // Register-file read with r0 hardwired to zero.
    function automatic logic [31:0] rf_sel(input logic [2:0] addr, input logic [31:0] data);
        logic [31:0] r;
        if (addr == 3'd0) begin
            r = 32'd0;
        end else begin
            r = data;
        end
        return r;
    endfunction

    assign instr_ready = ready_r;
    assign res_valid   = res_valid_r;
    assign alu_op      = alu_op_r;
    assign alu_a       = alu_a_r;
    assign alu_b       = alu_b_r;
    assign res_data    = res_data_r;
    assign res_rd      = res_rd_r;

    // Instruction field decode and operand fetch.
    always_comb begin
        op_s       = instr[31:29];
        rd_s       = instr[28:26];
        rs1_s      = instr[25:23];
        rs2_s      = instr[22:20];
        rs1_data_s = rf_sel(rs1_s, regs_r[rs1_s]);
        rs2_data_s = rf_sel(rs2_s, regs_r[rs2_s]);
`ifdef ALU_ISSUE_IMM_EN
        if (instr[19]) begin
            opb_s = {16'h0000, instr[15:0]};
        end else begin
            opb_s = rs2_data_s;
        end
        unused_instr_s = ^instr[18:16];
`else
        opb_s          = rs2_data_s;
        unused_instr_s = ^instr[19:0];
`endif
    end

    // Debug read port, combinational.
    always_comb begin
        dbg_data = rf_sel(dbg_addr, regs_r[dbg_addr]);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        accept_s = instr_valid && ready_r;
        state_s  = IDLE;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = EXEC;
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC:    state_s = WB;
            WB:      state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM output decode; handshake outputs are registered from the next state.
    always_comb begin
        ready_nxt_s = 1'b0;
        valid_nxt_s = 1'b0;
        wr_en_s     = 1'b0;
        case (state_r)
            EXEC: begin
                valid_nxt_s = 1'b1;
                wr_en_s     = (rd_r != 3'd0);
            end
            IDLE:    ready_nxt_s = 1'b0;
            WB:      ready_nxt_s = 1'b0;
            default: ready_nxt_s = 1'b0;
        endcase
        if (state_s == IDLE) begin
            ready_nxt_s = 1'b1;
        end else begin
            ready_nxt_s = 1'b0;
        end
    end

    // Registered handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r     <= 1'b1;
            res_valid_r <= 1'b0;
        end else begin
            ready_r     <= ready_nxt_s;
            res_valid_r <= valid_nxt_s;
        end
    end

    // ALU operand issue; operands hold outside the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op_r <= 3'd0;
            alu_a_r  <= 32'd0;
            alu_b_r  <= 32'd0;
            rd_r     <= 3'd0;
        end else if (accept_s) begin
            alu_op_r <= op_s;
            alu_a_r  <= rs1_data_s;
            alu_b_r  <= opb_s;
            rd_r     <= rd_s;
        end
    end

    // Result capture at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data_r <= 32'd0;
            res_rd_r   <= 3'd0;
        end else if (state_r == EXEC) begin
            res_data_r <= alu_y;
            res_rd_r   <= rd_r;
        end
    end

    // Register file writeback; r0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if (wr_en_s) begin
            regs_r[rd_r] <= alu_y;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: table-driven self-checking bench for alu_issue with a bench-side ALU and result scoreboard.
// Works with or without ALU_ISSUE_IMM_EN defined.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = 32'd0;
    logic [2:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic        res_valid;
    logic [31:0] res_data;
    logic [2:0]  res_rd;
    logic [2:0]  dbg_addr = 3'd0;
    logic [31:0] dbg_data;

    logic        ovr_en = 1'b0;
    logic [31:0] ovr_val = 32'd0;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_pulse = 0;
    int n_issued = 0;

    typedef struct packed {
        logic [2:0]  rd;
        logic [31:0] y;
    } sb_t;
    sb_t sb_q[$];

    typedef struct packed {
        logic [2:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic        sel;
        logic [15:0] imm;
        logic        ovr;
        logic [31:0] ov;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] ey;
    } vec_t;

    vec_t        vecs [10];
    logic [31:0] mregs [8];

    alu_issue dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (b >= 32'd32) ? 32'd0 : (a << b);
            3'd6: return (b >= 32'd32) ? 32'd0 : (a >> b);
            default: return ~a;
        endcase
    endfunction

    assign alu_y = ovr_en ? ovr_val : alu_fn(alu_op, alu_a, alu_b);

    function automatic vec_t mk(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                                input logic [2:0] rs2, input logic sel, input logic [15:0] imm,
                                input logic ovr, input logic [31:0] ov, input logic [31:0] ea,
                                input logic [31:0] eb, input logic [31:0] ey);
        vec_t v;
        v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.sel = sel; v.imm = imm;
        v.ovr = ovr; v.ov = ov; v.ea = ea; v.eb = eb; v.ey = ey;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: every result pulse must match the oldest pending issue.
    always @(posedge clk) begin
        #1;
        if (res_valid === 1'b1) begin
            n_pulse++;
            if (sb_q.size() == 0) begin
                check("unexpected_res_valid", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check("res_data", res_data, e.y);
                check("res_rd", {29'd0, res_rd}, {29'd0, e.rd});
            end
        end
    end

    task automatic check_all_clear(input string nm);
        check({nm, "_ready"}, {31'd0, instr_ready}, 32'd1);
        check({nm, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        check({nm, "_alu_op"}, {29'd0, alu_op}, 32'd0);
        check({nm, "_alu_a"}, alu_a, 32'd0);
        check({nm, "_alu_b"}, alu_b, 32'd0);
        check({nm, "_res_data"}, res_data, 32'd0);
        check({nm, "_res_rd"}, {29'd0, res_rd}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check({nm, "_dbg"}, dbg_data, 32'd0);
        end
    endtask

    task automatic issue(input vec_t v);
        int n;
        n = 0;
        while (instr_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {31'd0, instr_ready}, 32'd1);
        @(negedge clk);
        instr       = {v.op, v.rd, v.rs1, v.rs2, v.sel, 3'b101, v.imm};
        ovr_en      = v.ovr;
        ovr_val     = v.ov;
        instr_valid = 1'b1;
        @(posedge clk);
        sb_q.push_back({v.rd, v.ey});
        n_issued++;
        #1;
        instr_valid = 1'b0;
        instr       = 32'hDEAD_BEEF;
        check("alu_op", {29'd0, alu_op}, {29'd0, v.op});
        check("alu_a", alu_a, v.ea);
        check("alu_b", alu_b, v.eb);
        check("busy_ready_exec", {31'd0, instr_ready}, 32'd0);
        @(posedge clk);
        #2;
        check("hold_alu_a", alu_a, v.ea);
        check("hold_alu_b", alu_b, v.eb);
        check("busy_ready_wb", {31'd0, instr_ready}, 32'd0);
        @(posedge clk);
        #2;
        check("pulse_end", {31'd0, res_valid}, 32'd0);
        check("ready_back", {31'd0, instr_ready}, 32'd1);
        dbg_addr = v.rd;
        #1;
        check("dbg_wb", dbg_data, (v.rd == 3'd0) ? 32'd0 : v.ey);
        if (v.rd != 3'd0) mregs[v.rd] = v.ey;
        ovr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic        rdy;
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic [31:0] ea, eb, ey;
        logic [31:0] la, lb;
        int          accepts;

        for (int i = 0; i < 8; i++) mregs[i] = 32'd0;

`ifdef ALU_ISSUE_IMM_EN
        vecs[0] = mk(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0005, 1'b0, 32'd0, 32'd0, 32'd5, 32'd5);
        vecs[1] = mk(3'd0, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0003, 1'b0, 32'd0, 32'd0, 32'd3, 32'd3);
        vecs[4] = mk(3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 16'h1234, 1'b0, 32'd0, 32'd0, 32'h1234, 32'h1234);
        vecs[8] = mk(3'd0, 3'd5, 3'd7, 3'd2, 1'b1, 16'hFFFF, 1'b0, 32'd0, 32'hFFFF_FFFA, 32'h0000_FFFF, 32'h0000_FFF9);
`else
        vecs[0] = mk(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0005, 1'b1, 32'd5, 32'd0, 32'd0, 32'd5);
        vecs[1] = mk(3'd0, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0003, 1'b1, 32'd3, 32'd0, 32'd0, 32'd3);
        vecs[4] = mk(3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 16'h1234, 1'b1, 32'h1234, 32'd0, 32'd0, 32'h1234);
        vecs[8] = mk(3'd0, 3'd5, 3'd7, 3'd2, 1'b1, 16'hFFFF, 1'b0, 32'd0, 32'hFFFF_FFFA, 32'd3, 32'hFFFF_FFFD);
`endif
        vecs[2] = mk(3'd1, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000, 1'b0, 32'd0, 32'd5, 32'd3, 32'd2);
        vecs[3] = mk(3'd4, 3'd4, 3'd3, 3'd1, 1'b0, 16'h0000, 1'b0, 32'd0, 32'd2, 32'd5, 32'd7);
        vecs[5] = mk(3'd3, 3'd5, 3'd4, 3'd2, 1'b0, 16'h0000, 1'b0, 32'd0, 32'd7, 32'd3, 32'd7);
        vecs[6] = mk(3'd5, 3'd6, 3'd1, 3'd2, 1'b0, 16'h0000, 1'b0, 32'd0, 32'd5, 32'd3, 32'd40);
        vecs[7] = mk(3'd7, 3'd7, 3'd1, 3'd2, 1'b0, 16'h0000, 1'b0, 32'd0, 32'd5, 32'd3, 32'hFFFF_FFFA);
        vecs[9] = mk(3'd6, 3'd3, 3'd7, 3'd6, 1'b0, 16'h0000, 1'b0, 32'd0, 32'hFFFF_FFFA, 32'd40, 32'd0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all_clear("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_clear("post_reset");

        for (int i = 0; i < 10; i++) issue(vecs[i]);

        // Back-to-back handshake with instr_valid held high and instr changing every cycle
        accepts = 0;
        la = alu_a;
        lb = alu_b;
        @(negedge clk);
        instr_valid = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c != 0) @(negedge clk);
            s1 = 3'(c);
            s2 = 3'(c + 3);
            instr = {3'd4, 3'd6, s1, s2, 1'b0, 3'b000, 16'(c)};
            rdy = instr_ready;
            check("hs_ready", {31'd0, rdy}, {31'd0, (c % 3) == 0});
            ea = (s1 == 3'd0) ? 32'd0 : mregs[s1];
            eb = (s2 == 3'd0) ? 32'd0 : mregs[s2];
            ey = ea ^ eb;
            if (rdy !== 1'b1) begin
                check("hs_hold_a", alu_a, la);
                check("hs_hold_b", alu_b, lb);
            end
            @(posedge clk);
            if (rdy === 1'b1) begin
                sb_q.push_back({3'd6, ey});
                n_issued++;
                accepts++;
                mregs[6] = ey;
                la = ea;
                lb = eb;
                #1;
                check("hs_alu_a", alu_a, ea);
                check("hs_alu_b", alu_b, eb);
            end
        end
        @(negedge clk);
        instr_valid = 1'b0;
        check("hs_accepts", 32'(accepts), 32'd3);
        repeat (3) @(negedge clk);

        // Reset asserted in EXEC aborts the instruction
        instr       = {3'd0, 3'd3, 3'd1, 3'd2, 1'b0, 3'b000, 16'h0000};
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        check("abort_in_exec", {31'd0, instr_ready}, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_clear("abort");
        for (int i = 0; i < 8; i++) mregs[i] = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_all_clear("abort_release");

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        check("pulse_count", 32'(n_pulse), 32'(n_issued));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
